dmux_dispatch: RTL and testbench
================================

// Module: dmux_dispatch
// PURPOSE
//  Upstream feeder for the 4-lane nibble demux. Accepts a valid/ready stream of
//  4-bit words with a 2-bit destination tag and buffers them in a small FIFO.
//  Drives the demux data/select pair from a registered output stage under a
//  valid/ready handshake. Keeps saturating per-lane dispatch counters.
// PARAMETERS
//  DEPTH   4  FIFO entries; power of two, >= 2
//  CNT_W   8  width of each per-lane dispatch counter
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          reset, asynchronous, active-high
//  s_valid    in   1          upstream word valid
//  s_ready    out  1          upstream may push (= FIFO not full)
//  s_data     in   4          upstream data nibble
//  s_dest     in   2          destination lane tag (used when rr_mode=0)
//  rr_mode    in   1          1: round-robin lane select; 0: use stored tag
//  dm_valid   out  1          dm_in/dm_sel hold a word
//  dm_ready   in   1          downstream consumes the word this cycle
//  dm_in      out  4          data to the demux input
//  dm_sel     out  2          lane select to the demux
//  fifo_level out  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
//  clr_cnt    in   1          synchronous clear of all lane counters
//  lane_cnt   out  4*CNT_W    lane k count at [k*CNT_W +: CNT_W]
// BEHAVIOUR
//  Reset (async, rst=1): FIFO empty, fifo_level=0, dm_valid=0, dm_in=0,
//   dm_sel=0, rr pointer=0, lane_cnt=0. s_ready=1 while rst=1 and out of reset.
//  Push: s_valid & s_ready at an edge writes {s_dest,s_data} at the tail.
//   s_ready = (fifo_level != DEPTH), combinational from state only.
//  Load: at an edge, if FIFO non-empty and (!dm_valid | dm_ready), the head is
//   popped into the output register and dm_valid=1. Otherwise, if dm_ready,
//   dm_valid=0, and dm_in/dm_sel return to 0.
//  dm_in/dm_sel are 0 whenever dm_valid=0 (demux sees no spurious data).
//  Latency: word pushed at edge N appears on dm_* after edge N+1 (no bypass).
//   Full throughput: one word per cycle when s_valid and dm_ready stay high.
//  Lane select at load: rr_mode=0 -> stored tag. rr_mode=1 -> tag ignored,
//   dm_sel = rr pointer. Pointer increments on each load, wraps 3->0, and holds
//   its value while rr_mode=0. rr_mode is sampled at the load edge only.
//   A loaded word is never re-steered.
//  Push and pop in the same cycle: fifo_level is unchanged. When full, there is
//   no push, even if a pop occurs in that cycle (s_ready was already 0).
//  Counters: on dm_valid & dm_ready, lane_cnt[dm_sel] += 1 and saturates at
//   2^CNT_W-1. clr_cnt has priority over a same-cycle increment.
//  dm_valid must not drop without dm_ready. dm_in/dm_sel are stable while
//   dm_valid & !dm_ready.
//  rst mid-transfer discards all buffered and in-flight words immediately.
// STRUCTURE
//  Shared pkg dmux_pkg: LANES=4, SEL_W=2, DATA_W=4, and the lane-tag constants
//   LANE_A..LANE_D = 0..3.
//  Sub-module sync_fifo (WIDTH=SEL_W+DATA_W, DEPTH) with push/pop/full/empty/
//   level. Output register, rr pointer and counters live in dmux_dispatch.
// TESTING
//  1 Reset: assert rst mid-burst with 3 words queued -> dm_valid=0,
//    fifo_level=0, lane_cnt=0, s_ready=1 immediately.
//  2 Tagged: rr_mode=0, dm_ready=1, push (3,4'hA),(0,4'h5) back-to-back ->
//    dm_sel/dm_in = 3/A then 0/5 on consecutive cycles; lane_cnt[3]=1,
//    lane_cnt[0]=1.
//  3 Round-robin: rr_mode=1, push 6 words with tag 2 -> dm_sel sequence
//    0,1,2,3,0,1; lane counts 2,2,1,1.
//  4 Backpressure: dm_ready=0, push 5 words with DEPTH=4 -> s_ready=0 after
//    the 5th push (4 in FIFO + 1 in output reg), level=4, dm_* stable.
//    Then dm_ready=1 -> all 5 are delivered in order.
//  5 Saturation/clear: CNT_W=2, send 5 words to lane 1 -> lane_cnt[1]=3. Then
//    clr_cnt with a lane-1 transfer in the same cycle -> lane_cnt[1]=0.
//  6 Simultaneous push/pop at level 2 for 10 cycles -> level stays 2,
//    FIFO order is preserved.

Source files
------------

// File: rtl/dmux_pkg.sv
// dmux_pkg: shared lane/data widths, lane tags and the buffered entry layout
package dmux_pkg;
  localparam int LANES = 4;
  localparam int SEL_W = 2;
  localparam int DATA_W = 4;
  typedef logic [SEL_W-1:0] lane_t;
  localparam lane_t LANE_A = 2'd0;
  localparam lane_t LANE_B = 2'd1;
  localparam lane_t LANE_C = 2'd2;
  localparam lane_t LANE_D = 2'd3;
  typedef struct packed {
    lane_t dest;
    logic [DATA_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; push when full and pop when empty are ignored
module sync_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      level <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/dmux_dispatch.sv
// dmux_dispatch: buffers tagged nibbles and feeds the 4-lane demux through a registered valid/ready stage
module dmux_dispatch
  import dmux_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic [SEL_W-1:0]         s_dest,
  input  logic                     rr_mode,
  output logic                     dm_valid,
  input  logic                     dm_ready,
  output logic [DATA_W-1:0]        dm_in,
  output logic [SEL_W-1:0]         dm_sel,
  output logic [$clog2(DEPTH):0]   fifo_level,
  input  logic                     clr_cnt,
  output logic [LANES*CNT_W-1:0]   lane_cnt
);
  entry_t head, tail;
  logic full, empty, load;
  lane_t rr_ptr;
  logic [CNT_W-1:0] cnt [LANES];
  assign tail = '{dest: s_dest, data: s_data};
  assign s_ready = !full;
  assign load = !empty && (!dm_valid || dm_ready);
  sync_fifo #(.WIDTH(SEL_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(s_valid),
    .pop(load),
    .wdata(tail),
    .rdata(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  // steering is decided once at load and frozen in the output register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dm_valid <= 1'b0;
      dm_in <= '0;
      dm_sel <= '0;
      rr_ptr <= '0;
    end else if (load) begin
      dm_valid <= 1'b1;
      dm_in <= head.data;
      dm_sel <= rr_mode ? rr_ptr : head.dest;
      if (rr_mode) rr_ptr <= rr_ptr + 1'b1;
    end else if (dm_ready) begin
      dm_valid <= 1'b0;
      dm_in <= '0;
      dm_sel <= '0;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int k = 0; k < LANES; k++) cnt[k] <= '0;
    else if (clr_cnt)
      for (int k = 0; k < LANES; k++) cnt[k] <= '0;
    else if (dm_valid && dm_ready && cnt[dm_sel] != '1)
      cnt[dm_sel] <= cnt[dm_sel] + 1'b1;
  for (genvar i = 0; i < LANES; i++) begin : g_cnt
    assign lane_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
endmodule

// File: tb/tb_dmux_dispatch.sv
// tb_dmux_dispatch: directed scenario tasks with hand-computed expectations for dmux_dispatch
module tb_dmux_dispatch;
  localparam int CW = 2;
  logic clk = 0, rst = 1;
  logic s_valid = 0, s_ready, rr_mode = 0, dm_valid, dm_ready = 0, clr_cnt = 0;
  logic [3:0] s_data = 0, dm_in;
  logic [1:0] s_dest = 0, dm_sel;
  logic [2:0] fifo_level;
  logic [4*CW-1:0] lane_cnt;
  int pass = 0, total = 0;

  dmux_dispatch #(.DEPTH(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_dest(s_dest), .rr_mode(rr_mode), .dm_valid(dm_valid), .dm_ready(dm_ready),
    .dm_in(dm_in), .dm_sel(dm_sel), .fifo_level(fifo_level), .clr_cnt(clr_cnt),
    .lane_cnt(lane_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] lc(int k);
    return lane_cnt[k*CW +: CW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (s_ready !== 1'b1) $display("FAIL rst_s_ready got %b want 1", s_ready); else pass++;
    total++; if (dm_valid !== 1'b0) $display("FAIL rst_dm_valid got %b want 0", dm_valid); else pass++;
    total++; if (fifo_level !== 3'd0) $display("FAIL rst_level got %0d want 0", fifo_level); else pass++;
    total++; if ({dm_in, dm_sel} !== 6'd0) $display("FAIL rst_dm_out got %h/%h want 0/0", dm_sel, dm_in); else pass++;
    total++; if (lane_cnt !== '0) $display("FAIL rst_cnt got %h want 0", lane_cnt); else pass++;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_tagged();
    rr_mode = 0; dm_ready = 1;
    s_valid = 1; s_dest = 3; s_data = 4'hA;
    tick();
    s_dest = 0; s_data = 4'h5;
    tick();
    total++; if ({dm_valid, dm_sel, dm_in} !== {1'b1, 2'd3, 4'hA}) $display("FAIL tag_first got %b/%0d/%h want 1/3/a", dm_valid, dm_sel, dm_in); else pass++;
    s_valid = 0;
    tick();
    total++; if ({dm_valid, dm_sel, dm_in} !== {1'b1, 2'd0, 4'h5}) $display("FAIL tag_second got %b/%0d/%h want 1/0/5", dm_valid, dm_sel, dm_in); else pass++;
    total++; if (lc(3) !== 2'd1) $display("FAIL tag_cnt3 got %0d want 1", lc(3)); else pass++;
    tick();
    total++; if ({dm_valid, dm_sel, dm_in} !== 7'd0) $display("FAIL tag_idle got %b/%0d/%h want 0/0/0", dm_valid, dm_sel, dm_in); else pass++;
    total++; if (lc(0) !== 2'd1) $display("FAIL tag_cnt0 got %0d want 1", lc(0)); else pass++;
  endtask

  task automatic test_round_robin();
    clr_cnt = 1; tick(); clr_cnt = 0;
    rr_mode = 1; dm_ready = 1; s_dest = 2;
    for (int t = 0; t < 7; t++) begin
      s_valid = t < 6; s_data = 4'(t);
      tick();
      if (t >= 1) begin
        total++;
        if ({dm_valid, dm_sel, dm_in} !== {1'b1, 2'((t - 1) % 4), 4'(t - 1)})
          $display("FAIL rr_word%0d got %b/%0d/%h want 1/%0d/%h", t - 1, dm_valid, dm_sel, dm_in, (t - 1) % 4, t - 1);
        else pass++;
      end
    end
    s_valid = 0;
    tick();
    total++; if (lane_cnt !== {2'd1, 2'd1, 2'd2, 2'd2}) $display("FAIL rr_counts got %h want 5a", lane_cnt); else pass++;
    rr_mode = 0;
  endtask

  task automatic test_backpressure();
    dm_ready = 0; clr_cnt = 1; tick(); clr_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      total++; if (s_ready !== 1'b1) $display("FAIL bp_ready%0d got %b want 1", i, s_ready); else pass++;
      s_valid = 1; s_dest = 2'(i); s_data = 4'(8 + i);
      tick();
    end
    total++; if (s_ready !== 1'b0) $display("FAIL bp_full got %b want 0", s_ready); else pass++;
    total++; if (fifo_level !== 3'd4) $display("FAIL bp_level got %0d want 4", fifo_level); else pass++;
    s_data = 4'hF; s_dest = 3;
    tick();
    total++; if ({fifo_level, dm_valid, dm_sel, dm_in} !== {3'd4, 1'b1, 2'd0, 4'h8}) $display("FAIL bp_hold got %0d/%b/%0d/%h want 4/1/0/8", fifo_level, dm_valid, dm_sel, dm_in); else pass++;
    s_valid = 0; dm_ready = 1;
    for (int j = 1; j < 5; j++) begin
      tick();
      total++;
      if ({dm_valid, dm_sel, dm_in} !== {1'b1, 2'(j), 4'(8 + j)})
        $display("FAIL bp_drain%0d got %b/%0d/%h want 1/%0d/%h", j, dm_valid, dm_sel, dm_in, j, 8 + j);
      else pass++;
    end
    tick();
    total++; if ({dm_valid, fifo_level} !== 4'd0) $display("FAIL bp_empty got %b/%0d want 0/0", dm_valid, fifo_level); else pass++;
    total++; if (lane_cnt !== {2'd1, 2'd1, 2'd1, 2'd2}) $display("FAIL bp_counts got %h want 56", lane_cnt); else pass++;
  endtask

  task automatic test_saturation();
    clr_cnt = 1; tick(); clr_cnt = 0;
    dm_ready = 1; s_dest = 1;
    for (int t = 0; t < 7; t++) begin
      s_valid = t < 5; s_data = 4'(t);
      tick();
    end
    total++; if (lc(1) !== 2'd3) $display("FAIL sat_cnt got %0d want 3", lc(1)); else pass++;
    s_valid = 1; tick();
    s_valid = 0; tick();
    total++; if ({dm_valid, dm_sel} !== {1'b1, 2'd1}) $display("FAIL sat_load got %b/%0d want 1/1", dm_valid, dm_sel); else pass++;
    clr_cnt = 1; tick(); clr_cnt = 0;
    total++; if (lane_cnt !== '0) $display("FAIL clr_prio got %h want 0", lane_cnt); else pass++;
    total++; if (dm_valid !== 1'b0) $display("FAIL clr_done got %b want 0", dm_valid); else pass++;
  endtask

  task automatic test_back_to_back();
    dm_ready = 0; s_valid = 1;
    for (int n = 0; n < 3; n++) begin
      s_data = 4'(n); s_dest = 2'(n);
      tick();
    end
    total++; if ({fifo_level, dm_in} !== {3'd2, 4'h0}) $display("FAIL b2b_fill got %0d/%h want 2/0", fifo_level, dm_in); else pass++;
    dm_ready = 1;
    for (int c = 0; c < 10; c++) begin
      s_data = 4'(3 + c); s_dest = 2'(3 + c);
      tick();
      total++;
      if (fifo_level !== 3'd2) $display("FAIL b2b_level%0d got %0d want 2", c, fifo_level); else pass++;
      total++;
      if ({dm_sel, dm_in} !== {2'(c + 1), 4'(c + 1)}) $display("FAIL b2b_order%0d got %0d/%h want %0d/%h", c, dm_sel, dm_in, (c + 1) % 4, c + 1); else pass++;
    end
    s_valid = 0;
    tick(); tick(); tick();
    total++; if ({dm_valid, fifo_level} !== 4'd0) $display("FAIL b2b_drain got %b/%0d want 0/0", dm_valid, fifo_level); else pass++;
  endtask

  task automatic test_reset_mid();
    dm_ready = 0; s_valid = 1;
    for (int n = 0; n < 4; n++) begin
      s_data = 4'(n + 1); s_dest = 2'(n);
      tick();
    end
    s_valid = 0;
    total++; if ({fifo_level, dm_valid} !== {3'd3, 1'b1}) $display("FAIL mid_queued got %0d/%b want 3/1", fifo_level, dm_valid); else pass++;
    total++; if (lane_cnt === '0) $display("FAIL mid_cnt_pre got %h want nonzero", lane_cnt); else pass++;
    rst = 1;
    #1;
    total++; if ({dm_valid, dm_sel, dm_in} !== 7'd0) $display("FAIL mid_rst_out got %b/%0d/%h want 0/0/0", dm_valid, dm_sel, dm_in); else pass++;
    total++; if (fifo_level !== 3'd0) $display("FAIL mid_rst_level got %0d want 0", fifo_level); else pass++;
    total++; if (lane_cnt !== '0) $display("FAIL mid_rst_cnt got %h want 0", lane_cnt); else pass++;
    total++; if (s_ready !== 1'b1) $display("FAIL mid_rst_ready got %b want 1", s_ready); else pass++;
    tick();
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_tagged();
    test_round_robin();
    test_backpressure();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
